exc_sequencer: RTL and testbench
================================

# exc_sequencer

Multi-cycle exception sequencer for the CPU core; it owns the select of the 5-way memory-address mux (PC, ALUOut, vectors 253/254/255). With no exception pending, it passes the main control unit's address select straight through. On an invalid-opcode, overflow or divide-by-zero event it stalls the core and runs a fixed sequence:
- saves EPC;
- points memory at the matching vector byte;
- waits out memory latency;
- loads PC from the fetched byte.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in cycles (legal 1..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ctrl_addr_sel  input  3  address-mux select requested by main control unit.
- exc_opcode  input  1  invalid-opcode event, sampled every cycle.
- exc_overflow  input  1  ALU overflow event, sampled every cycle.
- exc_div0  input  1  divide-by-zero event, sampled every cycle.
- mem_addr_sel  output  3  drives address-mux selector.
- mem_read  output  1  memory read strobe for the vector fetch.
- epc_write  output  1  EPC load enable; the datapath supplies PC-4.
- pc_write  output  1  PC load enable during the sequence.
- pc_from_vec  output  1  PC source = zero-extended memory byte.
- busy  output  1  stalls main control unit.
- done  output  1  one-cycle completion pulse.
- cause  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0.
- exc_lost  output  1  sticky: an exception arrived while busy.

## Operation
- States: IDLE, SAVE_EPC, ADDR, WAIT, LOAD_PC, DONE.
- IDLE:
  - mem_addr_sel = ctrl_addr_sel (combinational pass-through).
  - All strobes are 0 and busy = 0.
  - Any exc_* high -> SAVE_EPC; cause latched at the same edge.
- Priority when several exc_* are high in the same cycle: opcode > overflow > div0.
- SAVE_EPC: epc_write=1, busy=1 -> ADDR.
- ADDR:
  - mem_addr_sel = vector select: opcode 3'b010 (253), overflow 3'b011 (254), div0 3'b100 (255).
  - mem_read=1; wait counter loaded with MEM_LAT -> WAIT.
- WAIT:
  - Vector select held, mem_read=0.
  - Counter decrements each cycle; at 1 -> LOAD_PC.
- LOAD_PC: vector select held, pc_write=1, pc_from_vec=1 -> DONE.
- DONE: done=1, busy=1, mem_addr_sel=3'b000 -> IDLE.
- Outside IDLE, mem_addr_sel never follows ctrl_addr_sel.
- Any exc_* high in a non-IDLE state is ignored for sequencing and sets exc_lost. exc_lost clears only on reset.
- cause holds its value after DONE until the next exception is accepted.

## Timing
- Reset (asserted at any time, including mid-sequence) forces immediately:
  - state IDLE, counter 0, cause 00, exc_lost 0;
  - all strobes 0, busy 0, done 0;
  - mem_addr_sel = ctrl_addr_sel.
- Exception sampled at edge N:
  - SAVE_EPC in cycle N+1, ADDR in N+2;
  - WAIT in N+3..N+2+MEM_LAT;
  - LOAD_PC in N+3+MEM_LAT, DONE in N+4+MEM_LAT;
  - IDLE in N+5+MEM_LAT.
- busy is high for exactly 4+MEM_LAT cycles (6 at the default).
- A new exception is accepted in the first IDLE cycle after DONE; there is no dead cycle beyond that.
- All outputs except mem_addr_sel in IDLE are pure functions of registered state.

## Structure
- Shared package cpu_ctrl_pkg:
  - state enum;
  - address-select constants SEL_PC=000, SEL_ALUOUT=001, SEL_V253=010, SEL_V254=011, SEL_V255=100;
  - cause codes.
- The main control unit and the address mux reuse the select constants.
- One natural sub-module: wait_counter (3-bit loadable down-counter with load, dec and zero/one flag). Everything else is a single FSM.

## Test plan
- Pass-through:
  - Stimulus: idle, ctrl_addr_sel sweeps 000..100.
  - Required: mem_addr_sel tracks it in the same cycle; busy=0.
- Overflow sequence, MEM_LAT=2:
  - Stimulus: exc_overflow pulse at edge N.
  - Required: epc_write at N+1; mem_addr_sel=011 with mem_read at N+2; pc_write+pc_from_vec at N+5; done at N+6; cause=10; busy for 6 cycles.
- Priority:
  - Stimulus: exc_opcode and exc_div0 high together.
  - Required: cause=01, vector select 010; div0 not serviced; exc_lost stays 0.
- Exception while busy:
  - Stimulus: exc_div0 during WAIT.
  - Required: sequence unchanged; exc_lost=1 and stays 1 through later idle cycles.
- Reset mid-sequence:
  - Stimulus: reset low during WAIT.
  - Required: busy=0, cause=00, mem_addr_sel=ctrl_addr_sel immediately. After release, a new exc_opcode runs the full sequence.
- MEM_LAT=1 and MEM_LAT=7:
  - Required: busy lasts 5 and 11 cycles respectively.
  - Back-to-back exceptions are accepted on the first IDLE cycle after DONE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer states, address-mux selects, exception causes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_ADDR,
    ST_WAIT,
    ST_LOAD_PC,
    ST_DONE
  } state_t;

  localparam logic [2:0] SEL_PC     = 3'b000;
  localparam logic [2:0] SEL_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_V253   = 3'b010;
  localparam logic [2:0] SEL_V254   = 3'b011;
  localparam logic [2:0] SEL_V255   = 3'b100;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV0     = 2'b11
  } cause_t;

  // Address-mux select of the vector byte that services a given cause.
  function automatic logic [2:0] vec_sel(input cause_t c);
    case (c)
      CAUSE_OPCODE:   return SEL_V253;
      CAUSE_OVERFLOW: return SEL_V254;
      CAUSE_DIV0:     return SEL_V255;
      default:        return SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_sequencer_wait_counter.sv
// 3-bit loadable down-counter timing the vector-fetch memory latency.
module wait_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_one
);

  logic [2:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_one = (r_count == 3'd1);

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer: owns the memory-address mux select and runs the
// save-EPC / vector-fetch / load-PC sequence when an exception event arrives.
module exc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ctrl_addr_sel,
  input  logic       exc_opcode,
  input  logic       exc_overflow,
  input  logic       exc_div0,
  output logic [2:0] mem_addr_sel,
  output logic       mem_read,
  output logic       epc_write,
  output logic       pc_write,
  output logic       pc_from_vec,
  output logic       busy,
  output logic       done,
  output logic [1:0] cause,
  output logic       exc_lost
);

  state_t r_state;
  state_t w_next;
  cause_t r_cause;
  cause_t w_new_cause;
  logic   r_exc_lost;
  logic   w_any_exc;
  logic   w_load;
  logic   w_dec;
  logic   w_one;

  assign w_any_exc = exc_opcode | exc_overflow | exc_div0;

  // Fixed priority when several events coincide: opcode > overflow > div0.
  always_comb begin
    w_new_cause = CAUSE_NONE;
    if (exc_opcode)        w_new_cause = CAUSE_OPCODE;
    else if (exc_overflow) w_new_cause = CAUSE_OVERFLOW;
    else if (exc_div0)     w_new_cause = CAUSE_DIV0;
  end

  wait_counter u_wait_counter (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (3'(MEM_LAT)),
    .i_dec      (w_dec),
    .o_one      (w_one)
  );

  // State register, cause latch on acceptance, sticky lost-exception flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cause    <= CAUSE_NONE;
      r_exc_lost <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_any_exc) r_cause <= w_new_cause;
      if ((r_state != ST_IDLE) && w_any_exc) r_exc_lost <= 1'b1;
    end
  end

  // Next-state and per-state strobes; only IDLE forwards the control select.
  always_comb begin
    w_next       = r_state;
    mem_addr_sel = SEL_PC;
    mem_read     = 1'b0;
    epc_write    = 1'b0;
    pc_write     = 1'b0;
    pc_from_vec  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_addr_sel = ctrl_addr_sel;
        busy         = 1'b0;
        if (w_any_exc) w_next = ST_SAVE_EPC;
      end
      ST_SAVE_EPC: begin
        epc_write = 1'b1;
        w_next    = ST_ADDR;
      end
      ST_ADDR: begin
        mem_addr_sel = vec_sel(r_cause);
        mem_read     = 1'b1;
        w_load       = 1'b1;
        w_next       = ST_WAIT;
      end
      ST_WAIT: begin
        mem_addr_sel = vec_sel(r_cause);
        w_dec        = 1'b1;
        if (w_one) w_next = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        mem_addr_sel = vec_sel(r_cause);
        pc_write     = 1'b1;
        pc_from_vec  = 1'b1;
        w_next       = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign cause    = r_cause;
  assign exc_lost = r_exc_lost;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer at MEM_LAT 2 (main), 1 and 7.
module tb_exc_sequencer;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ctrl;
  logic       eo, ev, ed;

  logic [2:0] s2_sel, s1_sel, s7_sel;
  logic       s2_rd, s2_epc, s2_pcw, s2_pcv, s2_busy, s2_done, s2_lost;
  logic       s1_rd, s1_epc, s1_pcw, s1_pcv, s1_busy, s1_done, s1_lost;
  logic       s7_rd, s7_epc, s7_pcw, s7_pcv, s7_busy, s7_done, s7_lost;
  logic [1:0] s2_cause, s1_cause, s7_cause;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  exc_sequencer #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl),
    .exc_opcode(eo), .exc_overflow(ev), .exc_div0(ed),
    .mem_addr_sel(s2_sel), .mem_read(s2_rd), .epc_write(s2_epc),
    .pc_write(s2_pcw), .pc_from_vec(s2_pcv), .busy(s2_busy),
    .done(s2_done), .cause(s2_cause), .exc_lost(s2_lost)
  );

  exc_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl),
    .exc_opcode(eo), .exc_overflow(ev), .exc_div0(ed),
    .mem_addr_sel(s1_sel), .mem_read(s1_rd), .epc_write(s1_epc),
    .pc_write(s1_pcw), .pc_from_vec(s1_pcv), .busy(s1_busy),
    .done(s1_done), .cause(s1_cause), .exc_lost(s1_lost)
  );

  exc_sequencer #(.MEM_LAT(7)) dut7 (
    .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl),
    .exc_opcode(eo), .exc_overflow(ev), .exc_div0(ed),
    .mem_addr_sel(s7_sel), .mem_read(s7_rd), .epc_write(s7_epc),
    .pc_write(s7_pcw), .pc_from_vec(s7_pcv), .busy(s7_busy),
    .done(s7_done), .cause(s7_cause), .exc_lost(s7_lost)
  );

  typedef struct {
    logic [2:0] ctrl;
    logic [2:0] exp_sel;
  } pt_t;

  typedef struct {
    logic       o, v, d;
    logic [1:0] c;
    logic [2:0] vs;
  } scen_t;

  logic [10:0] sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] mk(input logic [2:0] sel, input logic rd, input logic epc,
                                     input logic pcw, input logic pcv, input logic bsy,
                                     input logic dn, input logic [1:0] c);
    return {sel, rd, epc, pcw, pcv, bsy, dn, c};
  endfunction

  function automatic logic [10:0] obs2();
    return {s2_sel, s2_rd, s2_epc, s2_pcw, s2_pcv, s2_busy, s2_done, s2_cause};
  endfunction

  // Expected per-cycle outputs of the MEM_LAT=2 instance, starting the cycle
  // after the accepting edge and ending with the first IDLE cycle.
  task automatic push_seq(input logic [1:0] c, input logic [2:0] vs, input logic [2:0] idle_sel);
    sbq.push_back(mk(SEL_PC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c));
    sbq.push_back(mk(vs,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c));
    for (int i = 0; i < 2; i++)
      sbq.push_back(mk(vs,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c));
    sbq.push_back(mk(vs,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c));
    sbq.push_back(mk(SEL_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c));
    sbq.push_back(mk(idle_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c));
  endtask

  // Drive one exception pulse, then pop and compare a record every cycle.
  // inj >= 0 raises exc_div0 for one cycle after record inj is checked.
  task automatic run_seq(input string nm, input logic o, input logic v, input logic d,
                         input logic [1:0] c, input logic [2:0] vs, input int inj);
    logic [10:0] exp;
    int k;
    k = 0;
    ctrl = SEL_ALUOUT;
    eo = o; ev = v; ed = d;
    push_seq(c, vs, SEL_ALUOUT);
    tick();
    eo = 1'b0; ev = 1'b0; ed = 1'b0;
    while (sbq.size() > 0) begin
      exp = sbq.pop_front();
      chk($sformatf("%s[%0d]", nm, k), {21'd0, obs2()}, {21'd0, exp});
      ed = (k == inj);
      if (sbq.size() > 0) tick();
      k++;
    end
    ed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pt_t   pt[5];
    scen_t sc[5];
    int    b1, b2, b7;
    logic [29:0] tr1, tr2, tr7, ex1, ex2, ex7;

    pt[0] = '{3'b000, 3'b000};
    pt[1] = '{3'b001, 3'b001};
    pt[2] = '{3'b010, 3'b010};
    pt[3] = '{3'b011, 3'b011};
    pt[4] = '{3'b100, 3'b100};

    sc[0] = '{1'b0, 1'b1, 1'b0, 2'b10, 3'b011};
    sc[1] = '{1'b1, 1'b0, 1'b1, 2'b01, 3'b010};
    sc[2] = '{1'b0, 1'b0, 1'b1, 2'b11, 3'b100};
    sc[3] = '{1'b1, 1'b1, 1'b1, 2'b01, 3'b010};
    sc[4] = '{1'b0, 1'b1, 1'b1, 2'b10, 3'b011};

    reset = 1'b0;
    ctrl  = 3'b011;
    eo = 1'b0; ev = 1'b0; ed = 1'b0;
    #1;
    chk("rst_busy",  {31'd0, s2_busy}, 32'd0);
    chk("rst_cause", {30'd0, s2_cause}, 32'd0);
    chk("rst_lost",  {31'd0, s2_lost}, 32'd0);
    chk("rst_sel",   {29'd0, s2_sel}, 32'd3);
    chk("rst_strb",  {28'd0, s2_rd, s2_epc, s2_pcw, s2_done}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      ctrl = pt[i].ctrl;
      #1;
      chk($sformatf("pass_sel[%0d]", i), {29'd0, s2_sel}, {29'd0, pt[i].exp_sel});
      chk($sformatf("pass_busy[%0d]", i), {31'd0, s2_busy}, 32'd0);
      tick();
    end

    for (int i = 0; i < 5; i++)
      run_seq($sformatf("scen%0d", i), sc[i].o, sc[i].v, sc[i].d, sc[i].c, sc[i].vs, -1);
    chk("prio_lost", {31'd0, s2_lost}, 32'd0);

    run_seq("busy_div0", 1'b0, 1'b1, 1'b0, 2'b10, SEL_V254, 2);
    chk("lost_set", {31'd0, s2_lost}, 32'd1);
    repeat (4) tick();
    chk("lost_sticky", {31'd0, s2_lost}, 32'd1);
    chk("lost_idle_busy", {31'd0, s2_busy}, 32'd0);

    ctrl = SEL_ALUOUT;
    ev = 1'b1;
    tick();
    ev = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", {31'd0, s2_busy}, 32'd1);
    ctrl = 3'b011;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_busy",  {31'd0, s2_busy}, 32'd0);
    chk("mid_cause", {30'd0, s2_cause}, 32'd0);
    chk("mid_sel",   {29'd0, s2_sel}, 32'd3);
    chk("mid_lost",  {31'd0, s2_lost}, 32'd0);
    chk("mid_strb",  {28'd0, s2_rd, s2_epc, s2_pcw, s2_done}, 32'd0);
    tick();
    chk("mid_hold_busy", {31'd0, s2_busy}, 32'd0);
    reset = 1'b1;
    tick();
    run_seq("post_rst", 1'b1, 1'b0, 1'b0, 2'b01, SEL_V253, -1);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    b1 = 0; b2 = 0; b7 = 0;
    ed = 1'b1;
    tick();
    ed = 1'b0;
    for (int i = 0; i < 15; i++) begin
      b1 += int'(s1_busy);
      b2 += int'(s2_busy);
      b7 += int'(s7_busy);
      tick();
    end
    chk("busy_len_lat1", b1, 32'd5);
    chk("busy_len_lat2", b2, 32'd6);
    chk("busy_len_lat7", b7, 32'd11);
    chk("lat7_cause", {30'd0, s7_cause}, 32'd3);

    eo = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      tr1[k] = s1_busy;
      tr2[k] = s2_busy;
      tr7[k] = s7_busy;
      ex1[k] = ((k % 6) != 5);
      ex2[k] = ((k % 7) != 6);
      ex7[k] = ((k % 12) != 11);
    end
    eo = 1'b0;
    chk("b2b_trace_lat1", {2'd0, tr1}, {2'd0, ex1});
    chk("b2b_trace_lat2", {2'd0, tr2}, {2'd0, ex2});
    chk("b2b_trace_lat7", {2'd0, tr7}, {2'd0, ex7});
    chk("b2b_lost_lat1", {31'd0, s1_lost}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
